// File: rtl/operand_loader.sv
// operand_loader
//
// Operand entry front end for the ALU datapath. A single raw load button is
// synchronized and debounced; each accepted press steps a fixed entry
// sequence (opcode, operand A, operand B, run) and captures the slide
// switches into the matching output register. A committed set is flagged
// by a `valid` level and a one-cycle `start` pulse. An asynchronous
// `cancel` request returns the sequence to opcode entry without touching
// the captured registers.
//
// Parameters
//   LENGTH_v         operand width in bits (>= 4)
//   DEBOUNCE_CYCLES  stable synchronized cycles needed to accept a level change (>= 2)
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   load_btn  in   raw push button, active-high, asynchronous
//   cancel    in   abort request, active-high, asynchronous
//   switches  in   slide switches, quasi-static
//   A, B      out  captured operands (signed)
//   control   out  captured opcode (switches[3:0])
//   valid     out  high while A/B/control form a committed set
//   start     out  one-cycle pulse when a set is committed
//   state     out  current entry state, for LEDs
//
// state  | meaning
// -------+-----------------------------------------------
// S_OP   | waiting for press to capture opcode
// S_A    | waiting for press to capture operand A
// S_B    | waiting for press to capture operand B, commit
// S_RUN  | committed set presented; press returns to S_OP

module operand_loader #(
    parameter int LENGTH_v        = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_btn,
    input  logic                       cancel,
    input  logic [LENGTH_v-1:0]        switches,
    output logic signed [LENGTH_v-1:0] A,
    output logic signed [LENGTH_v-1:0] B,
    output logic [3:0]                 control,
    output logic                       valid,
    output logic                       start,
    output logic [1:0]                 state
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OP  = 2'b00,
        S_A   = 2'b01,
        S_B   = 2'b10,
        S_RUN = 2'b11
    } state_t;

    state_t           state_q;
    logic             btn_meta, btn_sync;
    logic             cancel_meta, cancel_sync;
    logic [CNT_W-1:0] db_cnt;
    logic             db_level;
    logic             db_level_d;
    logic             press;

    assign state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            cancel_meta <= 1'b0;
            cancel_sync <= 1'b0;
        end else begin
            btn_meta    <= load_btn;
            btn_sync    <= btn_meta;
            cancel_meta <= cancel;
            cancel_sync <= cancel_meta;
        end
    end

    // Any cycle where the synchronized level agrees with the debounced level
    // clears the count, so a bounce restarts the qualification from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            db_level_d <= db_level;
            if (btn_sync != db_level) begin
                if (db_cnt == CNT_TC) begin
                    db_level <= btn_sync;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Rising edge of the debounced level only; releases produce no action.
    assign press = db_level & ~db_level_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_OP;
            A       <= '0;
            B       <= '0;
            control <= '0;
            valid   <= 1'b0;
            start   <= 1'b0;
        end else begin
            start <= 1'b0;
            if (cancel_sync) begin
                // A press coinciding with cancel is dropped here.
                state_q <= S_OP;
                valid   <= 1'b0;
            end else if (press) begin
                case (state_q)
                    S_OP: begin
                        control <= switches[3:0];
                        state_q <= S_A;
                    end
                    S_A: begin
                        A       <= switches;
                        state_q <= S_B;
                    end
                    S_B: begin
                        B       <= switches;
                        start   <= 1'b1;
                        valid   <= 1'b1;
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        valid   <= 1'b0;
                        state_q <= S_OP;
                    end
                    default: begin
                        valid   <= 1'b0;
                        state_q <= S_OP;
                    end
                endcase
            end
        end
    end

endmodule
